// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage with a small prefetch queue. A fetch PC register
// addresses instruction memory directly. Each fetch pushes {PC, instruction}
// into a circular queue, and decode pops from the head of that queue. A
// redirect from the control unit flushes the queue and reloads the PC.
//
// Parameters:
//   ADDRESS_WIDTH - PC / address width
//   DATA_WIDTH    - instruction and ImmOp width
//   DEPTH         - prefetch queue entries (power of two, >= 2)
//   RESET_PC      - PC value loaded on reset
//
// Ports:
//   clk, rst              - rising-edge clock, synchronous active-high reset
//   PCsrc                 - redirect request
//   jalrmuxSel            - redirect base select: 1 = rd1 (jalr), 0 = branch_pc
//   ImmOp                 - sign-extended redirect offset
//   rd1, branch_pc        - redirect base candidates
//   imem_addr, imem_rdata - instruction memory port (combinational read)
//   out_valid, out_ready  - decode handshake on the queue head
//   out_instr, out_pc     - head entry contents
//   count                 - current queue occupancy
//
// Configuration macro:
//   FETCH_JALR_LSB_CLEAR_EN - when defined, jalr targets have bit 0 cleared
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PCsrc,
    input  logic                          jalrmuxSel,
    input  logic [DATA_WIDTH-1:0]         ImmOp,
    input  logic [ADDRESS_WIDTH-1:0]      rd1,
    input  logic [ADDRESS_WIDTH-1:0]      branch_pc,
    output logic [ADDRESS_WIDTH-1:0]      imem_addr,
    input  logic [DATA_WIDTH-1:0]         imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_instr,
    output logic [ADDRESS_WIDTH-1:0]      out_pc,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]            head_q, head_d;
    logic [PW-1:0]            tail_q, tail_d;
    logic [CW-1:0]            count_q, count_d;
    logic [ADDRESS_WIDTH-1:0] pc_mem_q [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem_d [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_mem_d [DEPTH];

    logic [ADDRESS_WIDTH-1:0] redirect_base;
    logic [ADDRESS_WIDTH-1:0] redirect_target;
    logic                     push;
    logic                     pop;

    assign imem_addr = pc_q;
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_instr = instr_mem_q[head_q];
    assign out_pc    = pc_mem_q[head_q];

    // A full queue may still fetch when the head leaves in the same cycle.
    // A redirect suppresses both push and pop.
    assign push = ((count_q < FULL_COUNT) || (out_valid && out_ready)) && !PCsrc;
    assign pop  = out_valid && out_ready && !PCsrc;

    // Redirect target. Offset width is adapted to the address width.
    always_comb begin
        redirect_base   = jalrmuxSel ? rd1 : branch_pc;
        redirect_target = redirect_base + ADDRESS_WIDTH'(ImmOp);
`ifdef FETCH_JALR_LSB_CLEAR_EN
        if (jalrmuxSel) begin
            redirect_target[0] = 1'b0;
        end
`else
`endif
    end

    // Next-state for PC, pointers, occupancy and queue storage.
    always_comb begin
        pc_d        = pc_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (PCsrc) begin
            pc_d    = redirect_target;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_mem_d[tail_q]    = pc_q;
                instr_mem_d[tail_q] = imem_rdata;
                tail_d              = tail_q + PW'(1);
                pc_d                = pc_q + ADDRESS_WIDTH'(4);
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            // Pointers wrap naturally since DEPTH is a power of two.
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state; reset dominates redirect and fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible while count != 0.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Instruction memory is modelled as a pure
// function of the address so expected head instructions can be recomputed
// from expected PCs.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PCsrc;
    logic        jalrmuxSel;
    logic [31:0] ImmOp;
    logic [31:0] rd1;
    logic [31:0] branch_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [2:0]  count;

    int vectors    = 0;
    int miscompares = 0;

    fetch_unit #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH   (32),
        .DEPTH        (4),
        .RESET_PC     (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PCsrc     (PCsrc),
        .jalrmuxSel(jalrmuxSel),
        .ImmOp     (ImmOp),
        .rd1       (rd1),
        .branch_pc (branch_pc),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .count     (count)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: mem[addr>>2] as a fixed pattern of the word index.
    function automatic logic [31:0] instr_at(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        return 32'hC0DE_0000 ^ (idx * 32'h0001_0003);
    endfunction

    assign imem_rdata = instr_at(imem_addr);

    // Drive all control inputs in one step.
    task automatic applyStimulus(input logic r, input logic src, input logic jsel,
                                 input logic [31:0] imm, input logic [31:0] base1,
                                 input logic [31:0] bpc, input logic rdy);
        rst        = r;
        PCsrc      = src;
        jalrmuxSel = jsel;
        ImmOp      = imm;
        rd1        = base1;
        branch_pc  = bpc;
        out_ready  = rdy;
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("reset_count", {29'b0, count}, 32'd0);
        checkOutput("reset_pc", imem_addr, 32'h0);
        checkOutput("reset_valid", {31'b0, out_valid}, 32'd0);

        // Fill with decode stalled.
        tick();
        checkOutput("fill1_count", {29'b0, count}, 32'd1);
        checkOutput("fill1_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("fill1_pc", out_pc, 32'h0);
        checkOutput("fill1_instr", out_instr, instr_at(32'h0));
        checkOutput("fill1_addr", imem_addr, 32'h4);
        tick();
        tick();
        tick();
        checkOutput("full_count", {29'b0, count}, 32'd4);
        checkOutput("full_addr", imem_addr, 32'h10);
        checkOutput("full_head", out_pc, 32'h0);
        tick();
        checkOutput("stall_count", {29'b0, count}, 32'd4);
        checkOutput("stall_addr", imem_addr, 32'h10);

        // Full queue streaming: push and pop together.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("stream1_count", {29'b0, count}, 32'd4);
        checkOutput("stream1_pc", out_pc, 32'h4);
        checkOutput("stream1_addr", imem_addr, 32'h14);
        tick();
        checkOutput("stream2_count", {29'b0, count}, 32'd4);
        checkOutput("stream2_pc", out_pc, 32'h8);
        checkOutput("stream2_instr", out_instr, instr_at(32'h8));
        checkOutput("stream2_addr", imem_addr, 32'h18);

        // Branch redirect with a full queue: 0x8 + (-8) = 0x0.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h8, 1'b1);
        tick();
        checkOutput("br_count", {29'b0, count}, 32'd0);
        checkOutput("br_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("br_addr", imem_addr, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        tick();
        checkOutput("br_first_pc", out_pc, 32'h0);
        checkOutput("br_first_count", {29'b0, count}, 32'd1);
        checkOutput("br_first_addr", imem_addr, 32'h4);
        tick();
        checkOutput("br_next_pc", out_pc, 32'h4);
        checkOutput("br_next_count", {29'b0, count}, 32'd1);

        // jalr redirect: 0x101 + 4.
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 32'h101, 32'h0, 1'b0);
        tick();
`ifdef FETCH_JALR_LSB_CLEAR_EN
        checkOutput("jalr_addr", imem_addr, 32'h104);
`else
        checkOutput("jalr_addr", imem_addr, 32'h105);
`endif
        checkOutput("jalr_count", {29'b0, count}, 32'd0);

        // Fill three entries, then reset together with a redirect.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("pre_rst_count", {29'b0, count}, 32'd3);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h100, 1'b1);
        tick();
        checkOutput("rst_mid_count", {29'b0, count}, 32'd0);
        checkOutput("rst_mid_addr", imem_addr, 32'h0);
        checkOutput("rst_mid_valid", {31'b0, out_valid}, 32'd0);

        // Redirect to the top of the address space, then wrap.
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 32'hFFFF_FFF0, 1'b0);
        tick();
        checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_head_instr", out_instr, instr_at(32'hFFFF_FFFC));
        checkOutput("wrap_count", {29'b0, count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters (name, default, meaning): ADDRESS_WIDTH, 32, PC/address width.
REQ-002 DATA_WIDTH, 32, instruction and ImmOp width.
REQ-003 DEPTH, 4, prefetch queue entries; power of two, >=2.
REQ-004 RESET_PC, 0, PC value loaded on reset.
REQ-005 Ports (name direction width meaning): clk in 1 sole clock, rising edge.
REQ-006 rst in 1 synchronous active-high reset.
REQ-007 PCsrc in 1 redirect request from control unit.
REQ-008 jalrmuxSel in 1 redirect is jalr (base rd1) when 1, branch/jal (base branch_pc) when 0.
REQ-009 ImmOp in DATA_WIDTH sign-extended offset.
REQ-010 rd1 in ADDRESS_WIDTH register-file read for jalr base.
REQ-011 branch_pc in ADDRESS_WIDTH PC of the redirecting instruction.
REQ-012 imem_addr out ADDRESS_WIDTH fetch address to instruction memory, equals fetch PC.
REQ-013 imem_rdata in DATA_WIDTH instruction memory data, combinational from imem_addr.
REQ-014 out_valid out 1 queue head holds a valid instruction.
REQ-015 out_ready in 1 decode accepts head this cycle.
REQ-016 out_instr out DATA_WIDTH head instruction; out_pc out ADDRESS_WIDTH head PC.
REQ-017 count out $clog2(DEPTH)+1 current queue occupancy.

Function
REQ-018 Fetch PC register drives imem_addr directly; no other logic on that path.
REQ-019 fetch_en = (count < DEPTH) or (out_valid and out_ready); redirect inactive.
REQ-020 On fetch_en, at clk edge, {PC, imem_rdata} is written at tail and PC <= PC + 4 (mod 2^ADDRESS_WIDTH).
REQ-021 When fetch_en is 0 and no redirect, PC holds.
REQ-022 Pop occurs when out_valid and out_ready and no redirect; head pointer advances.
REQ-023 out_valid = (count != 0); out_instr/out_pc driven combinationally from head entry.
REQ-024 Push and pop in the same cycle leave count unchanged, including when full.
REQ-025 Head/tail pointers wrap modulo DEPTH; count never exceeds DEPTH nor underflows.
REQ-026 Redirect (PCsrc=1): target = (jalrmuxSel ? rd1 : branch_pc) + ImmOp, truncated to ADDRESS_WIDTH.
REQ-027 Redirect has priority: queue flushed (count, head, tail <= 0), PC <= target, no push, no pop that cycle.
REQ-028 Latency: instruction at PC visible on out_valid one cycle after the fetch edge; first instruction after redirect appears two edges after PCsrc sampled.
REQ-029 out_ready while out_valid=0 has no effect.

Reset
REQ-030 rst sampled at clk edge only; has priority over redirect and fetch.
REQ-031 On reset: PC <= RESET_PC, count/head/tail <= 0, out_valid = 0, imem_addr = RESET_PC next cycle.
REQ-032 Reset mid-operation discards all queued entries; queue contents are not exposed afterwards.

Configuration
REQ-033 Macro FETCH_JALR_LSB_CLEAR_EN.
REQ-034 Defined: jalr target has bit 0 forced to 0 (RV32I semantics); branch targets unaffected.
REQ-035 Undefined: jalr target used unmodified, identical to branch target computation.

Verification
REQ-036 Reset, out_ready=0, imem_rdata=mem[addr>>2]: after 4 edges count=4, PC=0x10, fetch stalls, out_pc=0x0.
REQ-037 Full queue, out_ready=1 continuously: count stays 4, out_pc increments 0x0,0x4,0x8 each cycle.
REQ-038 PCsrc=1, jalrmuxSel=0, branch_pc=0x8, ImmOp=0xFFFFFFF8 with queue full: next cycle count=0, PC=0x0; following cycle out_pc=0x0.
REQ-039 PCsrc=1, jalrmuxSel=1, rd1=0x101, ImmOp=0x4: PC=0x104 with FETCH_JALR_LSB_CLEAR_EN, 0x105 without.
REQ-040 rst asserted with count=3 and PCsrc=1: next cycle count=0, PC=RESET_PC, out_valid=0.
REQ-041 PC=0xFFFFFFFC, fetch: PC wraps to 0x0, out_pc=0xFFFFFFFC at head.
